stereo_mix_accum: RTL and testbench

Parametrised stereo mix accumulator for the synth engine, successor to the fixed-width volume mixer. It takes one oscillator sample per valid cycle with voice velocity level and oscillator index, and applies per-oscillator level and pan through a fixed pipeline. Per-frame L/R sums are accumulated, then master volume with per-frame ramping and mute is applied, and the result is saturated into AUD_BIT_DEPTH output words with a valid strobe and a sticky clip flag. It sits between the envelope/sine LUT stage and the audio output (I2S) path.

---
 rtl/mixer_pkg.sv | 33 +++
 rtl/stereo_mix_accum_if.sv | 39 +++
 rtl/stereo_mix_accum_vol_ramp.sv | 49 ++++
 rtl/stereo_mix_accum.sv | 188 ++++++++++++++++++
 tb/tb_stereo_mix_accum.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mixer_pkg.sv
// Shared mixer widths, limits and helpers for the stereo and future surround mixers.
// Pure declarations: no latency, no flow control.
package mixer_pkg;

    localparam int P1_W    = 25;
    localparam int P2_W    = 33;
    localparam int P3_W    = 41;
    localparam int PAN_MAX = 127;
    localparam int VOL_MAX = 127;

    // Index width for n entries, never less than one bit.
    function automatic int clogb2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Clamp a wide signed value into a signed word of the given depth.
    function automatic logic signed [63:0] sat_resize(input logic signed [63:0] x,
                                                      input int unsigned depth);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (depth - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (depth - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/stereo_mix_accum_if.sv
// Oscillator-sample, control and mixed-output bundle of the stereo mix accumulator.
// Valid-only strobes: the sink must take every sample and output word.
interface stereo_mix_accum_if
    import mixer_pkg::*;
#(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int V_OSC         = 4
);
    localparam int O_WIDTH = clogb2(V_OSC);

    logic                            osc_valid;
    logic                            osc_last;
    logic        [O_WIDTH-1:0]       osc_sel;
    logic signed [16:0]              sine_lut_out;
    logic signed [7:0]               level_mul_vel;
    logic signed [7:0]               osc_lvl [V_OSC-1:0];
    logic signed [7:0]               osc_pan [V_OSC-1:0];
    logic signed [7:0]               m_vol;
    logic                            mute;
    logic                            clip_clr;
    logic signed [AUD_BIT_DEPTH-1:0] lsound_out;
    logic signed [AUD_BIT_DEPTH-1:0] rsound_out;
    logic                            out_valid;
    logic                            clip;
    logic        [7:0]               vol_cur;

    modport master (
        output osc_valid, osc_last, osc_sel, sine_lut_out, level_mul_vel,
               osc_lvl, osc_pan, m_vol, mute, clip_clr,
        input  lsound_out, rsound_out, out_valid, clip, vol_cur
    );

    modport slave (
        input  osc_valid, osc_last, osc_sel, sine_lut_out, level_mul_vel,
               osc_lvl, osc_pan, m_vol, mute, clip_clr,
        output lsound_out, rsound_out, out_valid, clip, vol_cur
    );

endinterface

// File: rtl/stereo_mix_accum_vol_ramp.sv
// Master-volume ramp: steps vol_cur toward the mute/m_vol target once per enabled cycle.
// One-cycle update on i_en; no backpressure.
module vol_ramp
    import mixer_pkg::*;
#(
    parameter int RAMP_STEP = 1
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic signed [7:0] i_m_vol,
    input  logic              i_mute,
    output logic        [7:0] o_vol_cur
);
    localparam logic [7:0] STEP = 8'(RAMP_STEP);
    localparam logic [7:0] VMAX = 8'(VOL_MAX);

    logic [7:0] r_vol;
    logic [7:0] w_target;
    logic [7:0] w_diff;
    logic [7:0] w_next;

    always_comb begin
        w_target = 8'd0;
        w_diff   = 8'd0;
        w_next   = r_vol;
        if (!i_mute && !i_m_vol[7]) begin
            w_target = ($unsigned(i_m_vol) > VMAX) ? VMAX : $unsigned(i_m_vol);
        end
        if (w_target > r_vol) begin
            w_diff = w_target - r_vol;
            w_next = (w_diff > STEP) ? r_vol + STEP : w_target;
        end else if (w_target < r_vol) begin
            w_diff = r_vol - w_target;
            w_next = (w_diff > STEP) ? r_vol - STEP : w_target;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vol <= 8'd0;
        end else if (i_en) begin
            r_vol <= w_next;
        end
    end

    assign o_vol_cur = r_vol;

endmodule

// File: rtl/stereo_mix_accum.sv
// Stereo oscillator mixer: level/pan pipeline, per-frame L/R accumulate, master volume, saturate.
// out_valid four edges after the last sample's edge; one sample per cycle, no backpressure.
module stereo_mix_accum
    import mixer_pkg::*;
#(
    parameter int AUD_BIT_DEPTH = 24,
    parameter int V_OSC         = 4,
    parameter int O_WIDTH       = clogb2(V_OSC),
    parameter int ACC_WIDTH     = 48,
    parameter int OUT_SHIFT     = 54 - AUD_BIT_DEPTH,
    parameter int RAMP_STEP     = 1
)(
    input  logic              sCLK_XVXENVS,
    input  logic              reset_reg_N,
    stereo_mix_accum_if.slave bus
);
    localparam int PROD_W = ACC_WIDTH + 9;

    logic                        r_s1_vld, r_s1_last;
    logic        [O_WIDTH-1:0]   r_s1_sel;
    logic signed [P1_W-1:0]      r_p1;
    logic signed [P1_W-1:0]      w_p1;

    logic                        r_s2_vld, r_s2_last;
    logic        [O_WIDTH-1:0]   r_s2_sel;
    logic signed [P2_W-1:0]      r_p2;
    logic signed [P2_W-1:0]      w_p2;
    logic signed [7:0]           w_lvl;

    logic                        r_s3_vld, r_s3_last;
    logic signed [P3_W-1:0]      r_pl, r_pr;
    logic signed [P3_W-1:0]      w_pl, w_pr;
    logic signed [7:0]           w_pan_raw;
    logic        [7:0]           w_pan, w_pan_l;

    logic signed [ACC_WIDTH-1:0] r_acc_l, r_acc_r;
    logic signed [ACC_WIDTH-1:0] r_hold_l, r_hold_r;
    logic                        r_hold_vld;
    logic signed [ACC_WIDTH-1:0] w_pl_ext, w_pr_ext;

    logic        [7:0]           w_vol;
    logic signed [8:0]           w_vol_s;
    logic signed [PROD_W-1:0]    w_prod_l, w_prod_r;
    logic signed [PROD_W-1:0]    w_shift_l, w_shift_r;
    logic signed [63:0]          w_wide_l, w_wide_r;
    logic signed [63:0]          w_satv_l, w_satv_r;
    logic                        w_clip_l, w_clip_r;

    logic signed [AUD_BIT_DEPTH-1:0] r_lsound, r_rsound;
    logic                            r_out_vld;
    logic                            r_clip;

    // S1: sample x envelope/velocity level.
    assign w_p1 = P1_W'(bus.sine_lut_out) * P1_W'(bus.level_mul_vel);

    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_sel  <= '0;
            r_p1      <= '0;
        end else begin
            r_s1_vld  <= bus.osc_valid;
            r_s1_last <= bus.osc_valid & bus.osc_last;
            r_s1_sel  <= bus.osc_sel;
            r_p1      <= w_p1;
        end
    end

    // S2: per-oscillator level.
    assign w_lvl = bus.osc_lvl[r_s1_sel];
    assign w_p2  = P2_W'(r_p1) * P2_W'(w_lvl);

    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_s2_vld  <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_sel  <= '0;
            r_p2      <= '0;
        end else begin
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_last;
            r_s2_sel  <= r_s1_sel;
            r_p2      <= w_p2;
        end
    end

    // S3: pan split; negative pan behaves as hard left.
    assign w_pan_raw = bus.osc_pan[r_s2_sel];
    assign w_pan     = w_pan_raw[7] ? 8'd0 : $unsigned(w_pan_raw);
    assign w_pan_l   = 8'(PAN_MAX) - w_pan;
    assign w_pl      = P3_W'(r_p2) * P3_W'($signed({1'b0, w_pan_l}));
    assign w_pr      = P3_W'(r_p2) * P3_W'($signed({1'b0, w_pan}));

    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_s3_vld  <= 1'b0;
            r_s3_last <= 1'b0;
            r_pl      <= '0;
            r_pr      <= '0;
        end else begin
            r_s3_vld  <= r_s2_vld;
            r_s3_last <= r_s2_last;
            r_pl      <= w_pl;
            r_pr      <= w_pr;
        end
    end

    assign w_pl_ext = ACC_WIDTH'(r_pl);
    assign w_pr_ext = ACC_WIDTH'(r_pr);

    // The last token hands the frame sum to hold and frees the accumulator in the
    // same edge, so a following frame can start with no gap.
    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_acc_l    <= '0;
            r_acc_r    <= '0;
            r_hold_l   <= '0;
            r_hold_r   <= '0;
            r_hold_vld <= 1'b0;
        end else begin
            r_hold_vld <= r_s3_vld & r_s3_last;
            if (r_s3_vld) begin
                if (r_s3_last) begin
                    r_hold_l <= r_acc_l + w_pl_ext;
                    r_hold_r <= r_acc_r + w_pr_ext;
                    r_acc_l  <= '0;
                    r_acc_r  <= '0;
                end else begin
                    r_acc_l  <= r_acc_l + w_pl_ext;
                    r_acc_r  <= r_acc_r + w_pr_ext;
                end
            end
        end
    end

    // Output: master volume, shift, saturate.
    assign w_vol_s   = $signed({1'b0, w_vol});
    assign w_prod_l  = PROD_W'(r_hold_l) * PROD_W'(w_vol_s);
    assign w_prod_r  = PROD_W'(r_hold_r) * PROD_W'(w_vol_s);
    assign w_shift_l = w_prod_l >>> OUT_SHIFT;
    assign w_shift_r = w_prod_r >>> OUT_SHIFT;
    assign w_wide_l  = 64'(w_shift_l);
    assign w_wide_r  = 64'(w_shift_r);
    assign w_satv_l  = sat_resize(w_wide_l, AUD_BIT_DEPTH);
    assign w_satv_r  = sat_resize(w_wide_r, AUD_BIT_DEPTH);
    assign w_clip_l  = (w_satv_l != w_wide_l);
    assign w_clip_r  = (w_satv_r != w_wide_r);

    always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_lsound  <= '0;
            r_rsound  <= '0;
            r_out_vld <= 1'b0;
            r_clip    <= 1'b0;
        end else begin
            r_out_vld <= r_hold_vld;
            if (r_hold_vld) begin
                r_lsound <= w_satv_l[AUD_BIT_DEPTH-1:0];
                r_rsound <= w_satv_r[AUD_BIT_DEPTH-1:0];
            end
            // A fresh clip outranks a clear in the same cycle.
            if (r_hold_vld && (w_clip_l || w_clip_r)) begin
                r_clip <= 1'b1;
            end else if (bus.clip_clr) begin
                r_clip <= 1'b0;
            end
        end
    end

    vol_ramp #(
        .RAMP_STEP (RAMP_STEP)
    ) u_vol_ramp (
        .i_clk     (sCLK_XVXENVS),
        .i_rst_n   (reset_reg_N),
        .i_en      (r_out_vld),
        .i_m_vol   (bus.m_vol),
        .i_mute    (bus.mute),
        .o_vol_cur (w_vol)
    );

    assign bus.lsound_out = r_lsound;
    assign bus.rsound_out = r_rsound;
    assign bus.out_valid  = r_out_vld;
    assign bus.clip       = r_clip;
    assign bus.vol_cur    = w_vol;

endmodule

// File: tb/tb_stereo_mix_accum.sv
// Directed bench for stereo_mix_accum with OUT_SHIFT=0 and hand-computed expectations.
module tb_stereo_mix_accum;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stereo_mix_accum_if #(.AUD_BIT_DEPTH(24), .V_OSC(4)) bus ();

    stereo_mix_accum #(
        .AUD_BIT_DEPTH (24),
        .V_OSC         (4),
        .ACC_WIDTH     (48),
        .OUT_SHIFT     (0),
        .RAMP_STEP     (1)
    ) dut (
        .sCLK_XVXENVS (clk),
        .reset_reg_N  (rst_n),
        .bus          (bus)
    );

    localparam longint SMAX = 8388607;
    localparam longint SMIN = -8388608;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [23:0] got_l, got_r;
    logic        [7:0]  got_vol;
    int                 got_lat;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat24(input longint x);
        if (x > SMAX) return SMAX;
        if (x < SMIN) return SMIN;
        return x;
    endfunction

    task automatic drive(input logic signed [16:0] s, input logic signed [7:0] vel,
                         input logic [1:0] sel, input logic last);
        @(negedge clk);
        bus.osc_valid     = 1'b1;
        bus.sine_lut_out  = s;
        bus.level_mul_vel = vel;
        bus.osc_sel       = sel;
        bus.osc_last      = last;
    endtask

    task automatic wait_out();
        got_lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.osc_valid = 1'b0;
            bus.osc_last  = 1'b0;
            if (bus.out_valid) begin
                got_lat = i;
                got_l   = bus.lsound_out;
                got_r   = bus.rsound_out;
                break;
            end
        end
    endtask

    // Single-sample frame; also captures vol_cur after the ramp update.
    task automatic frame1(input logic signed [16:0] s, input logic signed [7:0] vel,
                          input logic [1:0] sel);
        drive(s, vel, sel, 1'b1);
        wait_out();
        check("latency", got_lat, 5);
        @(negedge clk);
        got_vol = bus.vol_cur;
    endtask

    task automatic settle(input int tgt);
        for (int i = 0; i < 200 && int'(bus.vol_cur) != tgt; i++) frame1(17'sd1, 8'sd1, 2'd0);
        check("settle_vol", bus.vol_cur, tgt);
    endtask

    initial begin
        logic signed [23:0] bl [2];
        logic signed [23:0] br [2];
        int bidx [2];
        int nstb;

        bus.osc_valid = 0; bus.osc_last = 0; bus.osc_sel = 0;
        bus.sine_lut_out = 0; bus.level_mul_vel = 0;
        bus.m_vol = 8'sd10; bus.mute = 0; bus.clip_clr = 0;
        // sel0: lvl 1 pan 0; sel1: lvl 1 pan -5; sel2: lvl 127 pan 64; sel3: lvl 1 pan 64
        bus.osc_lvl[0] = 8'sd1;   bus.osc_pan[0] = 8'sd0;
        bus.osc_lvl[1] = 8'sd1;   bus.osc_pan[1] = -8'sd5;
        bus.osc_lvl[2] = 8'sd127; bus.osc_pan[2] = 8'sd64;
        bus.osc_lvl[3] = 8'sd1;   bus.osc_pan[3] = 8'sd64;

        repeat (2) @(negedge clk);
        check("rst_l", bus.lsound_out, 0);
        check("rst_r", bus.rsound_out, 0);
        check("rst_vld", bus.out_valid, 0);
        check("rst_clip", bus.clip, 0);
        check("rst_vol", bus.vol_cur, 0);
        rst_n = 1'b1;

        // Ramp from reset toward 10.
        for (int k = 1; k <= 12; k++) begin
            frame1(17'sd1, 8'sd1, 2'd0);
            check("ramp_l", got_l, 127 * ((k - 1 < 10) ? k - 1 : 10));
            check("ramp_r", got_r, 0);
            check("ramp_vol", got_vol, (k < 10) ? k : 10);
        end

        // Negative pan acts as hard left.
        frame1(17'sd100, 8'sd1, 2'd1);
        check("panneg_l", got_l, 100 * 127 * 10);
        check("panneg_r", got_r, 0);

        // Ramp down to 8.
        bus.m_vol = 8'sd8;
        frame1(17'sd1, 8'sd1, 2'd0);
        check("down_l0", got_l, 1270);
        check("down_vol0", got_vol, 9);
        frame1(17'sd1, 8'sd1, 2'd0);
        check("down_l1", got_l, 1143);
        check("down_vol1", got_vol, 8);

        // Back-to-back frames at vol 8.
        drive(17'sd5000, 8'sd1, 2'd3, 1'b0);
        drive(17'sd5000, 8'sd1, 2'd3, 1'b0);
        drive(17'sd5000, 8'sd1, 2'd3, 1'b1);
        drive(-17'sd5000, 8'sd1, 2'd3, 1'b1);
        nstb = 0; bidx[0] = 0; bidx[1] = 0;
        bl[0] = 0; bl[1] = 0; br[0] = 0; br[1] = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            bus.osc_valid = 1'b0;
            bus.osc_last  = 1'b0;
            if (bus.out_valid) begin
                if (nstb < 2) begin
                    bidx[nstb] = i;
                    bl[nstb]   = bus.lsound_out;
                    br[nstb]   = bus.rsound_out;
                end
                nstb++;
            end
        end
        check("b2b_count", nstb, 2);
        check("b2b_first", bidx[0], 4);
        check("b2b_gap", bidx[1] - bidx[0], 1);
        check("b2b_a_l", bl[0], 7560000);
        check("b2b_a_r", br[0], 7680000);
        check("b2b_b_l", bl[1], -2520000);
        check("b2b_b_r", br[1], -2560000);
        check("b2b_clip", bus.clip, 0);

        // Mute from a settled volume of 20.
        bus.m_vol = 8'sd20;
        settle(20);
        bus.mute = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            frame1(17'sd1, 8'sd1, 2'd0);
            check("mute_l", got_l, 127 * (21 - k));
        end
        check("mute_vol", got_vol, 0);
        frame1(17'sd1, 8'sd1, 2'd0);
        check("muted_l", got_l, 0);
        bus.mute = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            frame1(17'sd1, 8'sd1, 2'd0);
            check("unmute_l", got_l, 127 * (k - 1));
            check("unmute_vol", got_vol, k);
        end

        // Single-sample frame at full volume.
        bus.m_vol = 8'sd127;
        settle(127);
        frame1(17'sd1000, 8'sd127, 2'd2);
        check("single_l", got_l, sat24(longint'(1000) * 127 * 127 * 63 * 127));
        check("single_r", got_r, sat24(longint'(1000) * 127 * 127 * 64 * 127));
        check("single_clip", bus.clip, 1);

        // Saturation on both rails.
        frame1(17'sd65535, 8'sd127, 2'd2);
        check("satp_l", got_l, SMAX);
        check("satp_r", got_r, SMAX);
        frame1(-17'sd65536, 8'sd127, 2'd2);
        check("satn_l", got_l, SMIN);
        check("satn_r", got_r, SMIN);
        check("satn_clip", bus.clip, 1);

        // clip_clr coincident with a new clip: set wins.
        drive(17'sd65535, 8'sd127, 2'd2, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus.osc_valid = 1'b0;
            bus.osc_last  = 1'b0;
            if (i == 4) bus.clip_clr = 1'b1;
        end
        check("cc_strobe", bus.out_valid, 1);
        check("cc_clip", bus.clip, 1);
        bus.clip_clr = 1'b0;
        @(negedge clk);
        bus.clip_clr = 1'b1;
        @(negedge clk);
        bus.clip_clr = 1'b0;
        check("clr_clip", bus.clip, 0);
        frame1(17'sd65535, 8'sd127, 2'd2);
        check("reclip", bus.clip, 1);

        // Reset in the middle of a frame.
        drive(17'sd1, 8'sd1, 2'd0, 1'b0);
        drive(17'sd1, 8'sd1, 2'd0, 1'b0);
        @(negedge clk);
        bus.osc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_l", bus.lsound_out, 0);
        check("mrst_r", bus.rsound_out, 0);
        check("mrst_vld", bus.out_valid, 0);
        check("mrst_clip", bus.clip, 0);
        check("mrst_vol", bus.vol_cur, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nstb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) nstb++;
        end
        check("mrst_nostrobe", nstb, 0);
        frame1(17'sd1, 8'sd1, 2'd0);
        check("post_l0", got_l, 0);
        check("post_vol0", got_vol, 1);
        frame1(17'sd1, 8'sd1, 2'd0);
        check("post_l1", got_l, 127);
        check("post_vol1", got_vol, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
